// File: rtl/ifu_itcm_ctrl.sv
`default_nettype none
//============================================================================
//  Module      : ifu_itcm_ctrl
//  Description : Instruction-fetch controller sitting directly in front of the
//                IFU fetch stage. Accepts fetch requests, reads a single-port
//                ITCM SRAM with 1-cycle read latency, and returns instructions
//                strictly in request order. A 2-entry response FIFO absorbs
//                IFU back-pressure; while the FIFO is empty the SRAM data is
//                bypassed straight to the response port (1-cycle latency,
//                1 instruction/cycle throughput).
//  Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
//  Parameters
//    ITCM_AW        ITCM word-address width (2^ITCM_AW 32-bit words)
//    ITCM_BASE      ITCM byte base address, aligned to 2^(ITCM_AW+2)
//  Ports
//    clk            clock, rising edge
//    rst            synchronous, active-high reset
//    ifu_req_valid  fetch request valid
//    ifu_req_ready  controller can accept a request (registered state only)
//    ifu_req_pc     fetch byte address
//    ifu_rsp_valid  response valid (held with payload until accepted)
//    ifu_rsp_ready  IFU accepts the response
//    ifu_rsp_instr  fetched instruction
//    ifu_rsp_err    fetch fault; instruction is then a NOP
//    itcm_cs        SRAM read strobe
//    itcm_addr      SRAM word address
//    itcm_rdata     SRAM read data, valid the cycle after itcm_cs
//  Build option
//    ITCM_ERR_CHK_EN  when defined, misaligned or out-of-window fetches are
//                     faulted (no SRAM access, NOP returned with err=1).
//                     When undefined, address bits outside the word index
//                     are ignored and ifu_rsp_err is tied low.
//============================================================================

`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef INSTR_SIZE
`define INSTR_SIZE 32
`endif
`ifndef INSTR_NOP
`define INSTR_NOP 32'h0000_0013
`endif

module ifu_itcm_ctrl #(
    parameter int                  ITCM_AW   = 14,
    parameter logic [`PC_SIZE-1:0] ITCM_BASE = 32'h8000_0000
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   ifu_req_valid,
    output logic                   ifu_req_ready,
    input  logic [`PC_SIZE-1:0]    ifu_req_pc,

    output logic                   ifu_rsp_valid,
    input  logic                   ifu_rsp_ready,
    output logic [`INSTR_SIZE-1:0] ifu_rsp_instr,
    output logic                   ifu_rsp_err,

    output logic                   itcm_cs,
    output logic [ITCM_AW-1:0]     itcm_addr,
    input  logic [`INSTR_SIZE-1:0] itcm_rdata
);

    localparam logic [`INSTR_SIZE-1:0] c_nop = `INSTR_NOP;

    //------------------------------------------------------------------------
    // State
    //------------------------------------------------------------------------
    logic                   r_inflight;      // SRAM read issued last cycle
    logic                   r_inflight_err;  // ...and it was a faulted request
    logic [1:0]             r_cnt;           // FIFO occupancy, 0..2
    logic                   r_rd_ptr;
    logic                   r_wr_ptr;
    logic [`INSTR_SIZE-1:0] r_fifo_instr [2];
    logic                   r_fifo_err   [2];

    //------------------------------------------------------------------------
    // Combinational signals
    //------------------------------------------------------------------------
    logic                   w_fault;
    logic                   w_req_fire;
    logic                   w_rsp_fire;
    logic [2:0]             w_occupancy;
    logic                   w_fifo_empty;
    logic [`INSTR_SIZE-1:0] w_d_instr;
    logic                   w_d_err;
    logic                   w_push;
    logic                   w_pop;
    logic [`INSTR_SIZE-1:0] w_rsp_instr;
    logic                   w_rsp_err;

    //------------------------------------------------------------------------
    // Fault detection
    //------------------------------------------------------------------------
`ifdef ITCM_ERR_CHK_EN
    assign w_fault = (ifu_req_pc[1:0] != 2'b00) |
                     (ifu_req_pc[`PC_SIZE-1:ITCM_AW+2] != ITCM_BASE[`PC_SIZE-1:ITCM_AW+2]);
`else
    // Aliasing build: only the word index selects the SRAM location.
    logic w_unused_pc;
    assign w_fault     = 1'b0;
    assign w_unused_pc = ^{ifu_req_pc[`PC_SIZE-1:ITCM_AW+2], ifu_req_pc[1:0],
                           ITCM_BASE, w_rsp_err};
`endif

    //------------------------------------------------------------------------
    // Request side
    //------------------------------------------------------------------------
    // Credit rule: every accepted request owns either a FIFO slot or the
    // bypass, so the FIFO can never overflow. Depends on registered state
    // only, keeping ifu_rsp_ready off the request-side timing path.
    assign w_occupancy   = {1'b0, r_cnt} + {2'b00, r_inflight};
    assign ifu_req_ready = (w_occupancy <= 3'd1);
    assign w_req_fire    = ifu_req_valid & ifu_req_ready;

    assign itcm_cs   = w_req_fire & ~w_fault;
    assign itcm_addr = ifu_req_pc[ITCM_AW+1:2];

    //------------------------------------------------------------------------
    // Response side
    //------------------------------------------------------------------------
    // Data returning this cycle for the request accepted last cycle. A
    // faulted request never touched the SRAM, so itcm_rdata is stale there.
    assign w_d_instr = r_inflight_err ? c_nop : itcm_rdata;
    assign w_d_err   = r_inflight_err;

    assign w_fifo_empty  = (r_cnt == 2'd0);
    assign ifu_rsp_valid = ~w_fifo_empty | r_inflight;
    assign w_rsp_fire    = ifu_rsp_valid & ifu_rsp_ready;

    // The FIFO head always takes precedence so that order is preserved;
    // returning data only bypasses when nothing older is waiting.
    always_comb begin
        w_rsp_instr = '0;
        w_rsp_err   = 1'b0;
        if (!w_fifo_empty) begin
            w_rsp_instr = r_fifo_instr[r_rd_ptr];
            w_rsp_err   = r_fifo_err[r_rd_ptr];
        end else if (r_inflight) begin
            w_rsp_instr = w_d_instr;
            w_rsp_err   = w_d_err;
        end
    end

    // Returning data is parked in the FIFO unless it leaves via the bypass
    // this very cycle. Once parked, the head replays the same payload, which
    // keeps the response stable while the IFU stalls.
    assign w_push = r_inflight & ~(w_fifo_empty & ifu_rsp_ready);
    assign w_pop  = ~w_fifo_empty & w_rsp_fire;

    assign ifu_rsp_instr = w_rsp_instr;
`ifdef ITCM_ERR_CHK_EN
    assign ifu_rsp_err   = w_rsp_err;
`else
    assign ifu_rsp_err   = 1'b0;
`endif

    //------------------------------------------------------------------------
    // Sequential state
    //------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight     <= 1'b0;
            r_inflight_err <= 1'b0;
            r_cnt          <= 2'd0;
            r_rd_ptr       <= 1'b0;
            r_wr_ptr       <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_instr[i] <= '0;
                r_fifo_err[i]   <= 1'b0;
            end
        end else begin
            r_inflight     <= w_req_fire;
            r_inflight_err <= w_req_fire & w_fault;

            if (w_push) begin
                r_fifo_instr[r_wr_ptr] <= w_d_instr;
                r_fifo_err[r_wr_ptr]   <= w_d_err;
                r_wr_ptr               <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifu_itcm_ctrl.sv
`default_nettype none
//============================================================================
//  Module      : tb_ifu_itcm_ctrl
//  Description : Directed self-checking bench for ifu_itcm_ctrl with an
//                SRAM model, an in-order scoreboard for stalled traffic and
//                a FIFO overflow monitor.
//  Revision    : 1.0 - initial release
//============================================================================

module tb_ifu_itcm_ctrl;

    localparam int          c_aw   = 14;
    localparam logic [31:0] c_nop  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ifu_req_valid = 1'b0;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc = 32'h0;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready = 1'b0;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        itcm_cs;
    logic [c_aw-1:0] itcm_addr;
    logic [31:0] itcm_rdata = 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    ifu_itcm_ctrl #(
        .ITCM_AW   (c_aw),
        .ITCM_BASE (32'h8000_0000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ifu_req_valid (ifu_req_valid),
        .ifu_req_ready (ifu_req_ready),
        .ifu_req_pc    (ifu_req_pc),
        .ifu_rsp_valid (ifu_rsp_valid),
        .ifu_rsp_ready (ifu_rsp_ready),
        .ifu_rsp_instr (ifu_rsp_instr),
        .ifu_rsp_err   (ifu_rsp_err),
        .itcm_cs       (itcm_cs),
        .itcm_addr     (itcm_addr),
        .itcm_rdata    (itcm_rdata)
    );

    always #5 clk = ~clk;

    // SRAM content: a recognisable pattern derived from the word address.
    function automatic logic [31:0] mem_word(input logic [c_aw-1:0] a);
        return {16'hC0DE, 2'b00, a};
    endfunction

    // SRAM model: 1-cycle read latency, output holds its last value otherwise.
    always @(posedge clk) begin
        if (itcm_cs) itcm_rdata <= mem_word(itcm_addr);
    end

    // Expected {err, instr} for a fetch of byte address pc.
    function automatic logic [32:0] exp_rsp(input logic [31:0] pc);
        logic flt;
`ifdef ITCM_ERR_CHK_EN
        flt = (pc[1:0] != 2'b00) || (pc[31:16] != 16'h8000);
`else
        flt = 1'b0;
`endif
        return flt ? {1'b1, c_nop} : {1'b0, mem_word(pc[c_aw+1:2])};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    //------------------------------------------------------------------------
    // Scoreboard / stability monitor
    //------------------------------------------------------------------------
    logic        mon_en = 1'b0;
    logic [32:0] sb [$];
    logic        prev_stall = 1'b0;
    logic [32:0] prev_pay;

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (prev_stall) begin
                chk("stable_valid", {31'b0, ifu_rsp_valid}, 32'd1);
                chk("stable_instr", ifu_rsp_instr, prev_pay[31:0]);
                chk("stable_err", {31'b0, ifu_rsp_err}, {31'b0, prev_pay[32]});
            end
            if (ifu_rsp_valid && sb.size() == 0) begin
                chk("unexpected_rsp", {31'b0, ifu_rsp_valid}, 32'd0);
            end else if (ifu_rsp_valid && ifu_rsp_ready) begin
                logic [32:0] e;
                e = sb.pop_front();
                chk("order_instr", ifu_rsp_instr, e[31:0]);
                chk("order_err", {31'b0, ifu_rsp_err}, {31'b0, e[32]});
            end
            if (ifu_req_valid && ifu_req_ready) sb.push_back(exp_rsp(ifu_req_pc));
            prev_stall = ifu_rsp_valid && !ifu_rsp_ready;
            prev_pay   = {ifu_rsp_err, ifu_rsp_instr};
        end else begin
            prev_stall = 1'b0;
        end
    end

    // A FIFO push while full can only happen if the credit rule is broken.
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.w_push && dut.r_cnt == 2'd2)) else begin
                errors++;
                $error("FAIL overflow: push with cnt %0d, required no push", dut.r_cnt);
            end
        end
    end

    //------------------------------------------------------------------------
    // Directed stimulus
    //------------------------------------------------------------------------
    logic [31:0] pcs [8];
    int issued;
    int got;

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, ifu_req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'b0, ifu_rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'b0, ifu_rsp_err},   32'd0);
        chk("rst_rsp_instr", ifu_rsp_instr,          32'd0);
        chk("rst_cs",        {31'b0, itcm_cs},       32'd0);

        // ---------------- 1: streaming, no bubble ----------------
        ifu_rsp_ready = 1'b1;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0000;
        #1;
        chk("t1_cs0",   {31'b0, itcm_cs}, 32'd1);
        chk("t1_addr0", {18'b0, itcm_addr}, 32'd0);
        tick();
        ifu_req_pc = 32'h8000_0004;
        #1;
        chk("t1_addr1",  {18'b0, itcm_addr}, 32'd1);
        chk("t1_rdy1",   {31'b0, ifu_req_ready}, 32'd1);
        chk("t1_vld1",   {31'b0, ifu_rsp_valid}, 32'd1);
        chk("t1_instr0", ifu_rsp_instr, 32'hC0DE_0000);
        tick();
        ifu_req_pc = 32'h8000_0008;
        #1;
        chk("t1_addr2",  {18'b0, itcm_addr}, 32'd2);
        chk("t1_instr1", ifu_rsp_instr, 32'hC0DE_0001);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t1_instr2", ifu_rsp_instr, 32'hC0DE_0002);
        chk("t1_vld2",   {31'b0, ifu_rsp_valid}, 32'd1);
        tick();
        #1;
        chk("t1_idle",   {31'b0, ifu_rsp_valid}, 32'd0);

        // ---------------- 2: back-pressure fills FIFO ----------------
        ifu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0010;
        #1;
        chk("t2_rdyA", {31'b0, ifu_req_ready}, 32'd1);
        tick();
        ifu_req_pc = 32'h8000_0014;
        #1;
        chk("t2_rdyB", {31'b0, ifu_req_ready}, 32'd1);
        chk("t2_byp",  ifu_rsp_instr, 32'hC0DE_0004);
        tick();
        ifu_req_pc = 32'h8000_0018;
        #1;
        chk("t2_rdyC0", {31'b0, ifu_req_ready}, 32'd0);
        chk("t2_hold0", ifu_rsp_instr, 32'hC0DE_0004);
        tick();
        #1;
        chk("t2_cnt2",  {30'b0, dut.r_cnt}, 32'd2);
        chk("t2_rdyC1", {31'b0, ifu_req_ready}, 32'd0);
        ifu_rsp_ready = 1'b1;
        #1;
        chk("t2_popA",  ifu_rsp_instr, 32'hC0DE_0004);
        chk("t2_rdyC2", {31'b0, ifu_req_ready}, 32'd0);
        tick();
        #1;
        chk("t2_rdyC3", {31'b0, ifu_req_ready}, 32'd1);
        chk("t2_popB",  ifu_rsp_instr, 32'hC0DE_0005);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t2_rspC",  ifu_rsp_instr, 32'hC0DE_0006);
        chk("t2_vldC",  {31'b0, ifu_rsp_valid}, 32'd1);
        tick();
        #1;
        chk("t2_idle",  {31'b0, ifu_rsp_valid}, 32'd0);

        // ---------------- 4: mixed traffic, random ready ----------------
        pcs[0] = 32'h8000_0020;
`ifdef ITCM_ERR_CHK_EN
        pcs[1] = 32'h8000_0021;
        pcs[2] = 32'h7000_0024;
`else
        pcs[1] = 32'h8000_0024;
        pcs[2] = 32'h0000_0028;
`endif
        pcs[3] = 32'h8000_002C;
        pcs[4] = 32'h8000_0030;
`ifdef ITCM_ERR_CHK_EN
        pcs[5] = 32'h8000_0036;
`else
        pcs[5] = 32'h8000_0034;
`endif
        pcs[6] = 32'h8000_0038;
        pcs[7] = 32'h8000_003C;
        issued = 0;
        got    = 0;
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 200 && got < 8; cyc++) begin
            ifu_req_valid = (issued < 8);
            ifu_req_pc    = pcs[issued % 8];
            ifu_rsp_ready = 1'($urandom_range(0, 1));
            #1;
            if (ifu_req_valid && ifu_req_ready) issued++;
            if (ifu_rsp_valid && ifu_rsp_ready) got++;
            tick();
        end
        ifu_req_valid = 1'b0;
        chk("t4_issued", issued, 32'd8);
        chk("t4_got",    got,    32'd8);
        chk("t4_sb_empty", sb.size(), 32'd0);

        // ---------------- 5: reset mid-operation ----------------
        ifu_rsp_ready = 1'b0;
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0040;
        tick();
        ifu_req_pc = 32'h8000_0044;
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t5_pre_cnt",      {30'b0, dut.r_cnt}, 32'd1);
        chk("t5_pre_inflight", {31'b0, dut.r_inflight}, 32'd1);
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        #1;
        chk("t5_rsp_valid", {31'b0, ifu_rsp_valid}, 32'd0);
        chk("t5_req_ready", {31'b0, ifu_req_ready}, 32'd1);
        chk("t5_cs",        {31'b0, itcm_cs},       32'd0);
        mon_en        = 1'b1;
        ifu_rsp_ready = 1'b1;
        repeat (4) begin
            tick();
            #1;
            chk("t5_no_stale", {31'b0, ifu_rsp_valid}, 32'd0);
        end
        mon_en = 1'b0;

`ifdef ITCM_ERR_CHK_EN
        // ---------------- 3: faulted fetches ----------------
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h8000_0002;
        #1;
        chk("t3a_cs", {31'b0, itcm_cs}, 32'd0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t3a_vld",   {31'b0, ifu_rsp_valid}, 32'd1);
        chk("t3a_instr", ifu_rsp_instr, c_nop);
        chk("t3a_err",   {31'b0, ifu_rsp_err}, 32'd1);
        tick();
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h9000_0000;
        #1;
        chk("t3b_cs", {31'b0, itcm_cs}, 32'd0);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t3b_vld",   {31'b0, ifu_rsp_valid}, 32'd1);
        chk("t3b_instr", ifu_rsp_instr, c_nop);
        chk("t3b_err",   {31'b0, ifu_rsp_err}, 32'd1);
        tick();
`else
        // ---------------- 6: address aliasing ----------------
        ifu_req_valid = 1'b1;
        ifu_req_pc    = 32'h0000_0006;
        #1;
        chk("t6_cs",   {31'b0, itcm_cs}, 32'd1);
        chk("t6_addr", {18'b0, itcm_addr}, 32'd1);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        chk("t6_vld",   {31'b0, ifu_rsp_valid}, 32'd1);
        chk("t6_instr", ifu_rsp_instr, 32'hC0DE_0001);
        chk("t6_err",   {31'b0, ifu_rsp_err}, 32'd0);
        tick();
`endif
        #1;
        chk("end_idle", {31'b0, ifu_rsp_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
